// File: rtl/soc_rst_seq_if.sv
// soc_rst_seq_if: reset fan-out and soft-reset handshake bundle.
// Optional soft_rst_cnt present only with RST_SEQ_STAT_EN.
`timescale 1ns/1ps
interface soc_rst_seq_if #(
  parameter int NUM_RV  = 3,
  parameter int NUM_DSA = 3
);
  logic               mem_sub_sys_rstn;
  logic [NUM_DSA-1:0] dsa_rstn;
  logic [NUM_RV-1:0]  rv_rstn;
  logic [NUM_RV-1:0]  rv_rst_req;
  logic [NUM_RV-1:0]  rv_rst_ack;
  logic               seq_done;
`ifdef RST_SEQ_STAT_EN
  logic [NUM_RV*8-1:0] soft_rst_cnt;
`endif

  modport master (
    input  rv_rst_req,
`ifdef RST_SEQ_STAT_EN
    output soft_rst_cnt,
`endif
    output mem_sub_sys_rstn,
    output dsa_rstn,
    output rv_rstn,
    output rv_rst_ack,
    output seq_done
  );

  modport slave (
    output rv_rst_req,
`ifdef RST_SEQ_STAT_EN
    input  soft_rst_cnt,
`endif
    input  mem_sub_sys_rstn,
    input  dsa_rstn,
    input  rv_rstn,
    input  rv_rst_ack,
    input  seq_done
  );
endinterface

// File: rtl/soc_rst_seq.sv
// soc_rst_seq: ordered reset release (mem -> DSA -> RV) plus per-core soft reset.
// Optional macro RST_SEQ_STAT_EN adds per-core soft-reset completion counters.
`timescale 1ns/1ps
module soc_rst_seq #(
  parameter int NUM_RV   = 3,
  parameter int NUM_DSA  = 3,
  parameter int MEM_DLY  = 16,
  parameter int DSA_DLY  = 8,
  parameter int RV_DLY   = 8,
  parameter int SOFT_MIN = 4,
  parameter int CNT_W    = 8
) (
  input logic           clk,
  input logic           sys_rstn,
  soc_rst_seq_if.master bus
);

  localparam int CMAX = (2 ** CNT_W) - 1;

  if (MEM_DLY < 1 || MEM_DLY > CMAX ||
      DSA_DLY < 1 || DSA_DLY > CMAX ||
      RV_DLY < 1 || RV_DLY > CMAX ||
      SOFT_MIN < 1 || SOFT_MIN > CMAX) begin : g_bad_param
    $error("soc_rst_seq: delay parameters must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MEM_END  = CNT_W'(MEM_DLY - 1);
  localparam logic [CNT_W-1:0] DSA_END  = CNT_W'(DSA_DLY - 1);
  localparam logic [CNT_W-1:0] RV_END   = CNT_W'(RV_DLY - 1);
  localparam logic [CNT_W-1:0] SOFT_END = CNT_W'(SOFT_MIN - 1);

  typedef enum logic [2:0] {
    ST_RST,
    ST_WAIT_MEM,
    ST_WAIT_DSA,
    ST_WAIT_RV,
    ST_RUN
  } state_t;

  logic [1:0]         sync_q;
  logic               rst_sync;
  logic               rel_edge;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               mem_q;
  logic [NUM_DSA-1:0] dsa_q;
  logic [NUM_RV-1:0]  rv_q;
  logic [NUM_RV-1:0]  ack_q;
  logic               done_q;
  logic [CNT_W-1:0]   soft_cnt [NUM_RV];
`ifdef RST_SEQ_STAT_EN
  logic [NUM_RV-1:0][7:0] stat_q;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign rst_sync = sync_q[1];
  // Sequencing starts on the edge where rst_sync rises.
  assign rel_edge = sync_q[0] & ~rst_sync;

  // Two-flop release synchronizer, cleared asynchronously.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) sync_q <= '0;
    else           sync_q <= {sync_q[0], 1'b1};
  end

  // Boot FSM with registered reset outputs and per-core soft reset in RUN.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state  <= ST_RST;
      cnt    <= '0;
      mem_q  <= 1'b0;
      dsa_q  <= '0;
      rv_q   <= '0;
      ack_q  <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < NUM_RV; i++) soft_cnt[i] <= '0;
`ifdef RST_SEQ_STAT_EN
      stat_q <= '0;
`endif
    end else begin
      unique case (state)
        ST_RST: begin
          if (rel_edge) begin
            state <= ST_WAIT_MEM;
            cnt   <= '0;
          end
        end
        ST_WAIT_MEM: begin
          if (cnt == MEM_END) begin
            state <= ST_WAIT_DSA;
            cnt   <= '0;
            mem_q <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        ST_WAIT_DSA: begin
          if (cnt == DSA_END) begin
            state <= ST_WAIT_RV;
            cnt   <= '0;
            dsa_q <= '1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        ST_WAIT_RV: begin
          if (cnt == RV_END) begin
            state  <= ST_RUN;
            cnt    <= '0;
            rv_q   <= '1;
            done_q <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NUM_RV; i++) begin
            if (!ack_q[i]) begin
              if (bus.rv_rst_req[i]) begin
                ack_q[i]    <= 1'b1;
                rv_q[i]     <= 1'b0;
                soft_cnt[i] <= '0;
              end
            end else if (!bus.rv_rst_req[i] &&
                         soft_cnt[i] >= SOFT_END) begin
              ack_q[i] <= 1'b0;
              rv_q[i]  <= 1'b1;
`ifdef RST_SEQ_STAT_EN
              if (stat_q[i] != 8'hFF)
                stat_q[i] <= stat_q[i] + 8'd1;
`endif
            end else begin
              soft_cnt[i] <= sat_inc(soft_cnt[i]);
            end
          end
        end
        default: state <= ST_RST;
      endcase
    end
  end

  assign bus.mem_sub_sys_rstn = mem_q;
  assign bus.dsa_rstn         = dsa_q;
  assign bus.rv_rstn          = rv_q;
  assign bus.rv_rst_ack       = ack_q;
  assign bus.seq_done         = done_q;
`ifdef RST_SEQ_STAT_EN
  assign bus.soft_rst_cnt     = stat_q;
`endif

endmodule
